// File: rtl/btn_debounce_array.sv
// btn_debounce_array: per-channel synchronized, tick-sampled button debouncer with press/release pulses.
// Define BTN_LONG_PRESS_EN to add per-channel long-press detection and the btn_long port.
module btn_debounce_array #(
    parameter int NUM_BTNS   = 4,
    parameter int TICK_DIV   = 4000000,
    parameter int STABLE_CNT = 3,
    parameter int LONG_CNT   = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BTNS-1:0] raw_input,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
`ifdef BTN_LONG_PRESS_EN
    output logic [NUM_BTNS-1:0] btn_long,
`endif
    output logic [NUM_BTNS-1:0] btn_release
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(STABLE_CNT + 1);
    if (NUM_BTNS < 1 || NUM_BTNS > 32 || TICK_DIV < 2 || STABLE_CNT < 1 || STABLE_CNT > 255 || LONG_CNT < 1) begin : g_bad_param
        $error("btn_debounce_array: parameter out of range");
    end
    logic [TW-1:0]       tick_cnt;
    logic                tick;
    logic [NUM_BTNS-1:0] sync_a;
    logic [NUM_BTNS-1:0] sync_b;
    assign tick = tick_cnt == TW'(TICK_DIV - 1);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            sync_a   <= '0;
            sync_b   <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            sync_a   <= raw_input;
            sync_b   <= sync_a;
        end
    end
    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
        logic [SW-1:0] stab;
        logic          level;
        logic          press;
        logic          release_q;
        logic          differ;
        logic          accept;
        assign differ = sync_b[i] ^ level;
        // a matching sample on any tick throws away partial progress
        assign accept = tick & differ & (stab == SW'(STABLE_CNT - 1));
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                stab      <= '0;
                level     <= 1'b0;
                press     <= 1'b0;
                release_q <= 1'b0;
            end else begin
                if (tick)
                    stab <= (!differ || accept) ? '0 : stab + 1'b1;
                level     <= level ^ accept;
                press     <= accept & ~level;
                release_q <= accept & level;
            end
        end
        assign btn_level[i]   = level;
        assign btn_press[i]   = press;
        assign btn_release[i] = release_q;
`ifdef BTN_LONG_PRESS_EN
        localparam int LW = $clog2(LONG_CNT + 1);
        logic [LW-1:0] long_cnt;
        logic          long_q;
        // saturating at LONG_CNT makes the pulse fire once per press
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                long_cnt <= '0;
                long_q   <= 1'b0;
            end else begin
                long_cnt <= !level ? '0 : (tick && long_cnt != LW'(LONG_CNT)) ? long_cnt + 1'b1 : long_cnt;
                long_q   <= level & tick & (long_cnt == LW'(LONG_CNT - 1));
            end
        end
        assign btn_long[i] = long_q;
`endif
    end
endmodule

// File: tb/tb_btn_debounce_array.sv
// tb_btn_debounce_array: table-driven scoreboard bench for btn_debounce_array (small tick divider).
// Long-press checks are active when BTN_LONG_PRESS_EN is defined.
module tb_btn_debounce_array;
    localparam int N  = 4;
    localparam int TD = 4;
    localparam int SC = 3;
    localparam int LC = 5;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] raw_input = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
`ifdef BTN_LONG_PRESS_EN
    logic [N-1:0] btn_long;
`endif
    always #5 clk = ~clk;
    btn_debounce_array #(.NUM_BTNS(N), .TICK_DIV(TD), .STABLE_CNT(SC), .LONG_CNT(LC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .raw_input(raw_input),
        .btn_level(btn_level),
        .btn_press(btn_press),
`ifdef BTN_LONG_PRESS_EN
        .btn_long(btn_long),
`endif
        .btn_release(btn_release)
    );
    typedef struct {
        logic [3:0] raw;
        int         hold;
        logic [3:0] lvl;
        logic [3:0] pm;
        int         pc;
        logic [3:0] rm;
        int         rc;
        logic [3:0] lm;
        int         lc;
    } vec_t;
    vec_t       tbl[12];
    vec_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] pm_acc, rm_acc, lm_acc;
    int         pc_n, rc_n, lc_n;
    int         both_n = 0;
    int         cyc = 0;
    int         t_press = 0;
    int         t_long = 0;
    always @(posedge clk) begin
        #1;
        cyc++;
        if (btn_press != 0) begin
            pm_acc |= btn_press;
            pc_n++;
            if (btn_press[3]) t_press = cyc;
        end
        if (btn_release != 0) begin
            rm_acc |= btn_release;
            rc_n++;
        end
        if ((btn_press & btn_release) != 0) both_n++;
`ifdef BTN_LONG_PRESS_EN
        if (btn_long != 0) begin
            lm_acc |= btn_long;
            lc_n++;
            if (btn_long[3]) t_long = cyc;
        end
`endif
    end
    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask
    task automatic clr();
        pm_acc = '0; rm_acc = '0; lm_acc = '0;
        pc_n = 0; rc_n = 0; lc_n = 0;
    endtask
    task automatic compare(input int idx);
        vec_t e;
        e = sb.pop_front();
        chk($sformatf("v%0d level", idx), btn_level, e.lvl);
        chk($sformatf("v%0d press_mask", idx), pm_acc, e.pm);
        chk($sformatf("v%0d press_cycles", idx), pc_n, e.pc);
        chk($sformatf("v%0d release_mask", idx), rm_acc, e.rm);
        chk($sformatf("v%0d release_cycles", idx), rc_n, e.rc);
`ifdef BTN_LONG_PRESS_EN
        chk($sformatf("v%0d long_mask", idx), lm_acc, e.lm);
        chk($sformatf("v%0d long_cycles", idx), lc_n, e.lc);
        if (e.lc > 0) chk($sformatf("v%0d long_delay", idx), t_long - t_press, 5 * TD);
`endif
    endtask
    task automatic apply(input vec_t t, input int idx);
        raw_input = t.raw;
        clr();
        repeat (t.hold) @(negedge clk);
        sb.push_back(t);
        compare(idx);
    endtask
    // two differing ticks on ch2, then a one-clock reset must discard that progress
    task automatic reset_seq(input vec_t t, input int idx);
        raw_input = t.raw;
        clr();
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid level", btn_level, 0);
        chk("rst_mid press", btn_press, 0);
        chk("rst_mid release", btn_release, 0);
        clr();
        repeat (10) @(negedge clk);
        chk("rst_early level", btn_level, 0);
        chk("rst_early press_cycles", pc_n, 0);
        repeat (6) @(negedge clk);
        sb.push_back(t);
        compare(idx);
    endtask
    initial begin
        tbl[0]  = '{4'b0000, 16, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0};
        tbl[1]  = '{4'b0001, 16, 4'b0001, 4'b0001, 1, 4'b0000, 0, 4'b0000, 0};
        tbl[2]  = '{4'b0000, 16, 4'b0000, 4'b0000, 0, 4'b0001, 1, 4'b0000, 0};
        tbl[3]  = '{4'b0010,  8, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0};
        tbl[4]  = '{4'b0000, 16, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0};
        tbl[5]  = '{4'b1010, 16, 4'b1010, 4'b1010, 1, 4'b0000, 0, 4'b0000, 0};
        tbl[6]  = '{4'b0000, 16, 4'b0000, 4'b0000, 0, 4'b1010, 1, 4'b0000, 0};
        tbl[7]  = '{4'b0001, 16, 4'b0001, 4'b0001, 1, 4'b0000, 0, 4'b0000, 0};
        tbl[8]  = '{4'b0101,  0, 4'b0101, 4'b0101, 1, 4'b0000, 0, 4'b0000, 0};
        tbl[9]  = '{4'b0000, 16, 4'b0000, 4'b0000, 0, 4'b0101, 1, 4'b0000, 0};
        tbl[10] = '{4'b1000, 56, 4'b1000, 4'b1000, 1, 4'b0000, 0, 4'b1000, 1};
        tbl[11] = '{4'b0000, 16, 4'b0000, 4'b0000, 0, 4'b1000, 1, 4'b0000, 0};
        clr();
        repeat (3) @(negedge clk);
        chk("reset level", btn_level, 0);
        chk("reset press", btn_press, 0);
        chk("reset release", btn_release, 0);
`ifdef BTN_LONG_PRESS_EN
        chk("reset long", btn_long, 0);
`endif
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].hold == 0) reset_seq(tbl[i], i);
            else apply(tbl[i], i);
        end
        chk("press_and_release_same_cycle", both_n, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
